corr_multi: RTL and testbench
=============================

# corr_multi

Multi-pair rectangular-window correlator with an integrated packet serializer. Each of `N_PAIR` (x, y) bit pairs is sampled on an external strobe and counted over a power-of-two window: count of X, count of Y, intersection (X & Y) and symmetric difference (X ^ Y). At each window end all counts are snapshotted and streamed out as a byte packet over a valid/ready interface. This block replaces the single-pair correlator plus fifo in the correlator top level, and feeds the host byte-pipe directly.

## Interface
- `N_PAIR`, 4: number of (x, y) pairs, 1..8.
- `MAX_WINDOW_LENGTH_EXP`, 16: counter time width `TIME_W`, 8..16.
- `i_clk` in 1: sole clock.
- `i_rst_n` in 1: reset; one clock, reset is synchronous and active-low.
- `i_cg` in 1: clock gate; when 0, no state changes.
- `i_sampleStrobe` in 1: sample the inputs this cycle.
- `i_x`, `i_y` in `N_PAIR`: bit k belongs to pair k.
- `i_windowLengthExp` in `$clog2(MAX_WINDOW_LENGTH_EXP+1)`: window is 2^exp samples, 0..`TIME_W`.
- `i_clear` in 1: zero t and all counters; no packet emitted.
- `i_chEnable` in `N_PAIR`: pairs included in the packet (only with macro, see Configuration).
- `o_data` out 8: packet byte.
- `o_valid` out 1: `o_data` valid.
- `i_ready` in 1: consumer accepts when `o_valid && i_ready`.
- `o_busy` out 1: serializer not IDLE.
- `o_dropCount` out 8: saturating count of dropped windows.

## Operation
- t (`TIME_W` bits) increments on each strobe. Wrap is `strobe && (exp==0 || &t_q[exp-1:0])`. On wrap, t goes to 0.
- Per pair, there are four counters of `TIME_W+1` bits. On a strobe, each counter adds its bit. On wrap, each counter loads 0 and the snapshot receives count+bit, so the wrap sample is included.
- Reported byte = `(count << (TIME_W-exp))[TIME_W-1 -: 8]`. If `count == 2^exp`, the byte saturates to 8'hFF.
- `winNum` (8 bits) increments on every wrap, with or without a drop.
- Packet format:
  - byte0: `winNum` of the window.
  - byte1: `{dropped, 7'(nIncluded)}`.
  - then, for each included pair in ascending k: X, Y, Isect, Symdiff.
- Serializer FSM:
  - IDLE → HDR0 on a snapshot.
  - HDR0 → HDR1 on accept.
  - HDR1 → BODY on accept. If no pairs are included, HDR1 → IDLE instead.
  - BODY advances the byte index on accept. After the last byte is accepted, BODY → IDLE.
- A snapshot is loaded when the FSM is IDLE, or in the same cycle as the final byte's accept.
- A wrap while the FSM is busy (any other case) drops the window:
  - the snapshot is discarded;
  - `dropped` is set sticky;
  - `o_dropCount` increments, saturating at 255.
- `dropped` clears when byte1 is accepted. A drop in that same cycle re-sets it.
- `i_clear` has priority over strobe and wrap. It does not touch the FSM, `winNum` or `dropped`.
- `o_data` and `o_valid` are stable while `o_valid && !i_ready`.
- `i_windowLengthExp` is legal to change only together with `i_clear`. Values greater than `TIME_W` clamp to `TIME_W`.

## Timing
- Reset values (`!i_rst_n` at a clock edge):
  - FSM IDLE; t, counters, `winNum`, `dropped` = 0;
  - `o_valid` = 0, `o_data` = 0, `o_busy` = 0, `o_dropCount` = 0.
- Reset mid-packet aborts the packet immediately.
- Wrap at cycle n gives snapshot and `winNum` update at edge n+1. `o_valid` is 1 with byte0 from cycle n+1.
- Packet bytes are presented one per cycle while `i_ready` is high. The full packet takes 2+4·nIncluded accepted cycles.
- All outputs are registered.

## Configuration
- `CORR_MULTI_CHMASK_EN` defined:
  - `i_chEnable` exists and is sampled into the snapshot on wrap;
  - only enabled pairs are serialized;
  - nIncluded = popcount of the mask.
- Not defined:
  - port absent; all `N_PAIR` pairs are always sent;
  - nIncluded = `N_PAIR`;
  - the HDR1 → IDLE path is unreachable.

## Structure
- Package `corr_multi_pkg` holds:
  - FSM state enum (IDLE, HDR0, HDR1, BODY);
  - `PKT_HDR_BYTES` = 2 and `PKT_BYTES_PER_PAIR` = 4;
  - `MAX_N_PAIR` = 8.
- Sub-module `corr_multi_pair`, one per pair:
  - contains the four counters, the wrap-inclusive snapshot, and the scale/saturate logic;
  - outputs 4×8 report bytes.
- Top level holds t, `winNum`, the drop logic and the serializer.

## Test plan
- `N_PAIR`=2, exp=3, strobe every cycle, x0=1, y0=0, x1=y1=1, ready=1:
  - packet 00,02, then FF,00,00,FF, then FF,FF,FF,00;
  - next packet starts with byte0 = 01.
- exp=8, x0 high for 64 of 256 strobes, y0=0:
  - X byte = 0x40, Symdiff byte = 0x40, Isect byte = 0x00.
- exp=0, strobe every cycle, ready held low 20 cycles:
  - `o_dropCount` reaches ≥ 18;
  - on release the next packet header byte1 has bit7 = 1;
  - the following packet has bit7 = 0.
- Last body byte accepted in the same cycle as a wrap:
  - no drop; the next packet follows back-to-back with byte0 +1.
- `i_rst_n`=0 mid-BODY:
  - next cycle `o_valid`=0 and `o_dropCount`=0;
  - first packet after reset has byte0 = 00.
- With `CORR_MULTI_CHMASK_EN` and `i_chEnable`=0b10 (`N_PAIR`=2):
  - packet is 6 bytes, byte1 = 0x01, containing pair 1 only;
  - mask 0 gives a 2-byte packet.

Source files
------------

// File: rtl/corr_multi_pkg.sv
// corr_multi_pkg: serializer state type, packet geometry constants and a
// popcount helper shared by the multi-pair correlator.
package corr_multi_pkg;

  localparam int PKT_HDR_BYTES      = 2;
  localparam int PKT_BYTES_PER_PAIR = 4;
  localparam int MAX_N_PAIR         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR0 = 2'd1,
    HDR1 = 2'd2,
    BODY = 2'd3
  } serState_t;

  function automatic logic [3:0] popCount(input logic [MAX_N_PAIR-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_N_PAIR; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/corr_multi_pair.sv
// corr_multi_pair: X, Y, X&Y and X^Y window counters for one (x, y) pair,
// with a wrap-inclusive snapshot of the scaled, saturated report bytes.
module corr_multi_pair #(
  parameter int TIME_W = 16,
  parameter int EXP_W  = 5
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             cg,
  input  logic             strobe,
  input  logic             wrap,
  input  logic             clear,
  input  logic             snapLoad,
  input  logic             x,
  input  logic             y,
  input  logic [EXP_W-1:0] winExp,
  output logic [31:0]      repBytes
);

  logic [3:0]        sampleBits;
  logic [EXP_W-1:0]  shamt;
  logic [TIME_W:0]   fullCnt;

  assign sampleBits = {x ^ y, x & y, y, x};
  assign shamt      = EXP_W'(TIME_W) - winExp;
  assign fullCnt    = (TIME_W+1)'(1) << winExp;

  for (genvar gi = 0; gi < 4; gi++) begin : gCnt
    logic [TIME_W:0] cntReg;
    logic [TIME_W:0] total;
    logic [7:0]      scaledByte;
    logic [7:0]      snapReg;

    // total never exceeds 2^exp, so the left shift stays inside TIME_W+1 bits
    assign total      = cntReg + {{TIME_W{1'b0}}, sampleBits[gi]};
    assign scaledByte = 8'((total << shamt) >> (TIME_W - 8));

    always_ff @(posedge clk) begin
      if (!rstN) begin
        cntReg  <= '0;
        snapReg <= '0;
      end else if (cg) begin
        if (clear) begin
          cntReg <= '0;
        end else if (strobe) begin
          cntReg <= wrap ? '0 : total;
        end
        if (snapLoad) begin
          snapReg <= (total == fullCnt) ? 8'hFF : scaledByte;
        end
      end
    end

    assign repBytes[gi*8 +: 8] = snapReg;
  end

endmodule

// File: rtl/corr_multi.sv
// corr_multi: N_PAIR-way rectangular-window correlator feeding a byte-packet
// serializer. Define CORR_MULTI_CHMASK_EN to add the i_chEnable packet mask.
module corr_multi
  import corr_multi_pkg::*;
#(
  parameter int  N_PAIR                = 4,
  parameter int  MAX_WINDOW_LENGTH_EXP = 16,
  localparam int TIME_W                = MAX_WINDOW_LENGTH_EXP,
  localparam int EXP_W                 = $clog2(MAX_WINDOW_LENGTH_EXP + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cg,
  input  logic              i_sampleStrobe,
  input  logic [N_PAIR-1:0] i_x,
  input  logic [N_PAIR-1:0] i_y,
  input  logic [EXP_W-1:0]  i_windowLengthExp,
  input  logic              i_clear,
`ifdef CORR_MULTI_CHMASK_EN
  input  logic [N_PAIR-1:0] i_chEnable,
`endif
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic [7:0]        o_dropCount
);

  serState_t              stateReg, stateNext;
  logic [5:0]             idxReg, idxNext;
  logic [TIME_W-1:0]      tReg;
  logic [7:0]             winNumReg;
  logic                   droppedReg;
  logic [7:0]             dropCntReg;
  logic [7:0]             oDataReg, oDataNext;
  logic                   oValidReg, oValidNext;
  logic                   busyReg;
  logic [N_PAIR-1:0]      chMask;
  logic [N_PAIR*32-1:0]   repBytes;

  logic [EXP_W-1:0]       winExp;
  logic [TIME_W-1:0]      lowMask;
  logic                   wrap;
  logic                   accept;
  logic                   finalAccept;
  logic                   snapLoad;
  logic                   dropEvent;
  logic [3:0]             nIncl;
  logic [5:0]             lastIdx;
  logic [5:0]             bodyIdx;
  logic [3:0]             rank;
  logic [7:0]             bodyByte;

  assign winExp  = (i_windowLengthExp > EXP_W'(TIME_W)) ? EXP_W'(TIME_W) : i_windowLengthExp;
  assign lowMask = ~({TIME_W{1'b1}} << winExp);
  assign wrap    = i_cg && i_sampleStrobe && !i_clear && ((tReg & lowMask) == lowMask);

  assign nIncl       = popCount(MAX_N_PAIR'(chMask));
  assign lastIdx     = 6'(PKT_HDR_BYTES) + 6'(PKT_BYTES_PER_PAIR) * 6'(nIncl) - 6'd1;
  assign accept      = i_cg && oValidReg && i_ready;
  assign finalAccept = accept && (stateReg != IDLE) && (idxReg == lastIdx);
  // a window ending on the last byte's accept hands over without a gap
  assign snapLoad    = wrap && ((stateReg == IDLE) || finalAccept);
  assign dropEvent   = wrap && !snapLoad;

`ifdef CORR_MULTI_CHMASK_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      chMask <= '0;
    end else if (snapLoad) begin
      chMask <= i_chEnable;
    end
  end
`else
  assign chMask = '1;
`endif

  for (genvar gi = 0; gi < N_PAIR; gi++) begin : gPair
    corr_multi_pair #(
      .TIME_W (TIME_W),
      .EXP_W  (EXP_W)
    ) uPair (
      .clk      (i_clk),
      .rstN     (i_rst_n),
      .cg       (i_cg),
      .strobe   (i_sampleStrobe),
      .wrap     (wrap),
      .clear    (i_clear),
      .snapLoad (snapLoad),
      .x        (i_x[gi]),
      .y        (i_y[gi]),
      .winExp   (winExp),
      .repBytes (repBytes[gi*32 +: 32])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stateReg <= IDLE;
      idxReg   <= '0;
    end else if (i_cg) begin
      stateReg <= stateNext;
      idxReg   <= idxNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    idxNext   = idxReg;
    case (stateReg)
      IDLE: begin
        if (snapLoad) begin
          stateNext = HDR0;
          idxNext   = '0;
        end
      end
      default: begin
        if (accept) begin
          if (idxReg == lastIdx) begin
            stateNext = snapLoad ? HDR0 : IDLE;
            idxNext   = '0;
          end else begin
            stateNext = (stateReg == HDR0) ? HDR1 : BODY;
            idxNext   = idxReg + 6'd1;
          end
        end
      end
    endcase
  end

  // body byte n maps to field n%4 of the (n/4)-th included pair
  assign bodyIdx = idxNext - 6'(PKT_HDR_BYTES);

  always_comb begin
    bodyByte = '0;
    rank     = '0;
    for (int k = 0; k < N_PAIR; k++) begin
      if (chMask[k]) begin
        if (rank == bodyIdx[5:2]) begin
          bodyByte = repBytes[k*32 + 8*int'(bodyIdx[1:0]) +: 8];
        end
        rank = rank + 4'd1;
      end
    end
  end

  always_comb begin
    oValidNext = oValidReg;
    oDataNext  = oDataReg;
    if (!(oValidReg && !i_ready)) begin
      case (stateNext)
        IDLE: begin
          oValidNext = 1'b0;
          oDataNext  = 8'h00;
        end
        HDR0: begin
          oValidNext = 1'b1;
          oDataNext  = winNumReg;
        end
        HDR1: begin
          oValidNext = 1'b1;
          oDataNext  = {droppedReg | dropEvent, 7'(nIncl)};
        end
        default: begin
          oValidNext = 1'b1;
          oDataNext  = bodyByte;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tReg       <= '0;
      winNumReg  <= '0;
      droppedReg <= 1'b0;
      dropCntReg <= '0;
      oDataReg   <= '0;
      oValidReg  <= 1'b0;
      busyReg    <= 1'b0;
    end else if (i_cg) begin
      if (i_clear) begin
        tReg <= '0;
      end else if (i_sampleStrobe) begin
        tReg <= wrap ? '0 : tReg + 1'b1;
      end
      if (wrap) begin
        winNumReg <= winNumReg + 8'd1;
      end
      if (dropEvent) begin
        droppedReg <= 1'b1;
        if (dropCntReg != 8'hFF) begin
          dropCntReg <= dropCntReg + 8'd1;
        end
      end else if (accept && (stateReg == HDR1)) begin
        droppedReg <= 1'b0;
      end
      oDataReg  <= oDataNext;
      oValidReg <= oValidNext;
      busyReg   <= (stateNext != IDLE);
    end
  end

  assign o_data      = oDataReg;
  assign o_valid     = oValidReg;
  assign o_busy      = busyReg;
  assign o_dropCount = dropCntReg;

endmodule

// File: tb/tb_corr_multi.sv
// tb_corr_multi: directed-vector bench for corr_multi with two pairs; mask
// cases are compiled in when CORR_MULTI_CHMASK_EN is defined.
module tb_corr_multi;

  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          rstN;
  logic          cg;
  logic          strobe;
  logic          clr;
  logic          ready;
  logic [NP-1:0] x;
  logic [NP-1:0] y;
  logic [4:0]    wexp;
`ifdef CORR_MULTI_CHMASK_EN
  logic [NP-1:0] chEn;
`endif
  logic [7:0]    data;
  logic          valid;
  logic          busy;
  logic [7:0]    dropCnt;

  int            totalCnt = 0;
  int            badCnt   = 0;
  logic [7:0]    pkt [16];
  logic [7:0]    expT1 [10];

  always #5 clk = ~clk;

  corr_multi #(
    .N_PAIR                (NP),
    .MAX_WINDOW_LENGTH_EXP (16)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_cg              (cg),
    .i_sampleStrobe    (strobe),
    .i_x               (x),
    .i_y               (y),
    .i_windowLengthExp (wexp),
    .i_clear           (clr),
`ifdef CORR_MULTI_CHMASK_EN
    .i_chEnable        (chEn),
`endif
    .o_data            (data),
    .o_valid           (valid),
    .i_ready           (ready),
    .o_busy            (busy),
    .o_dropCount       (dropCnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    totalCnt++;
    if (got !== want) begin
      badCnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // collect n back-to-back bytes with ready high, bounded wait for the header
  task automatic getPacket(input int n, input string tag);
    int w;
    int gaps;
    w    = 0;
    gaps = 0;
    while (!valid && w < 100) begin
      step();
      w++;
    end
    chk({tag, "_start"}, 32'(valid), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (!valid) gaps++;
      pkt[i] = data;
      step();
    end
    chk({tag, "_gaps"}, 32'(gaps), 32'd0);
    $display("pkt %s: len=%0d b0=%02h b1=%02h b2=%02h", tag, n, pkt[0], pkt[1], pkt[2]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    expT1 = '{8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    rstN = 1'b0; cg = 1'b1; strobe = 1'b0; clr = 1'b0; ready = 1'b1;
    x = '0; y = '0; wexp = 5'd3;
`ifdef CORR_MULTI_CHMASK_EN
    chEn = 2'b11;
`endif
    step();
    step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(dropCnt), 32'd0);
    rstN = 1'b1;

    // exp=3, pair0 x only, pair1 x and y
    x = 2'b11; y = 2'b10; wexp = 5'd3;
    clr = 1'b1; step(); clr = 1'b0;
    strobe = 1'b1;
    repeat (8) step();
    strobe = 1'b0;
    getPacket(10, "t1a");
    for (int i = 0; i < 10; i++) chk($sformatf("t1_b%0d", i), 32'(pkt[i]), 32'(expT1[i]));
    chk("t1_drop", 32'(dropCnt), 32'd0);
    strobe = 1'b1;
    repeat (8) step();
    strobe = 1'b0;
    getPacket(10, "t1b");
    chk("t1b_b0", 32'(pkt[0]), 32'h01);

    // exp=8, x0 high for the first 64 of 256 strobes
    x = '0; y = '0; wexp = 5'd8;
    clr = 1'b1; step(); clr = 1'b0;
    strobe = 1'b1;
    for (int i = 0; i < 256; i++) begin
      x = (i < 64) ? 2'b01 : 2'b00;
      step();
    end
    strobe = 1'b0;
    getPacket(10, "t2");
    chk("t2_b0", 32'(pkt[0]), 32'h02);
    chk("t2_b1", 32'(pkt[1]), 32'h02);
    chk("t2_x0", 32'(pkt[2]), 32'h40);
    chk("t2_i0", 32'(pkt[4]), 32'h00);
    chk("t2_s0", 32'(pkt[5]), 32'h40);
    chk("t2_x1", 32'(pkt[6]), 32'h00);

    // exp=0, consumer stalled for 20 strobes
    ready = 1'b0; x = 2'b01; y = 2'b00; wexp = 5'd0;
    clr = 1'b1; step(); clr = 1'b0;
    strobe = 1'b1;
    repeat (20) step();
    strobe = 1'b0;
    chk("t3_dropcnt", 32'(dropCnt), 32'd19);
    chk("t3_hold_b0", 32'(data), 32'h03);
    ready = 1'b1;
    getPacket(10, "t3a");
    chk("t3a_b0", 32'(pkt[0]), 32'h03);
    chk("t3a_b1", 32'(pkt[1]), 32'h82);
    chk("t3a_x0", 32'(pkt[2]), 32'hFF);
    chk("t3a_s0", 32'(pkt[5]), 32'hFF);
    strobe = 1'b1; step(); strobe = 1'b0;
    getPacket(10, "t3b");
    chk("t3b_b0", 32'(pkt[0]), 32'h17);
    chk("t3b_b1", 32'(pkt[1]), 32'h02);

    // exp=1, second window ends exactly on the last byte's accept
    wexp = 5'd1;
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      strobe = (i == 1 || i == 2 || i == 7 || i == 12);
      step();
      if (i == 2) chk("t4_b0", 32'(data), 32'h18);
      if (i == 3) chk("t4_b1", 32'(data), 32'h02);
      if (i == 11) chk("t4_last_valid", 32'(valid), 32'd1);
    end
    strobe = 1'b0;
    chk("t4_b2b_valid", 32'(valid), 32'd1);
    chk("t4_b2b_b0", 32'(data), 32'h19);
    chk("t4_b2b_busy", 32'(busy), 32'd1);
    chk("t4_nodrop", 32'(dropCnt), 32'd19);
    getPacket(10, "t4b");
    chk("t4b_b1", 32'(pkt[1]), 32'h02);

    // clear beats a strobe; a gated clock freezes everything
    wexp = 5'd0;
    clr = 1'b1; strobe = 1'b1; step(); clr = 1'b0;
    chk("clr_nowrap", 32'(valid), 32'd0);
    cg = 1'b0; step();
    chk("cg_hold", 32'(valid), 32'd0);
    cg = 1'b1; strobe = 1'b0;

    // reset in the middle of the body
    strobe = 1'b1; step(); strobe = 1'b0;
    chk("t5_b0", 32'(data), 32'h1A);
    repeat (3) step();
    rstN = 1'b0; step();
    chk("t5_rst_valid", 32'(valid), 32'd0);
    chk("t5_rst_drop", 32'(dropCnt), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    rstN = 1'b1;
    strobe = 1'b1; step(); strobe = 1'b0;
    getPacket(10, "t5");
    chk("t5_after_b0", 32'(pkt[0]), 32'h00);

`ifdef CORR_MULTI_CHMASK_EN
    chEn = 2'b10; x = 2'b10; y = 2'b00;
    strobe = 1'b1; step(); strobe = 1'b0;
    getPacket(6, "m10");
    chk("m10_b1", 32'(pkt[1]), 32'h01);
    chk("m10_x1", 32'(pkt[2]), 32'hFF);
    chk("m10_y1", 32'(pkt[3]), 32'h00);
    chk("m10_s1", 32'(pkt[5]), 32'hFF);
    chk("m10_end", 32'(valid), 32'd0);
    chEn = 2'b00;
    strobe = 1'b1; step(); strobe = 1'b0;
    getPacket(2, "m00");
    chk("m00_b1", 32'(pkt[1]), 32'h00);
    chk("m00_end", 32'(valid), 32'd0);
    chEn = 2'b11;
`endif

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
